// File: rtl/apb_reg_slave_if.sv
// APB3 bus bundle between a requester and the apb_reg_slave completer.
//   paddr/pwrite/psel/penable/pwdata : requester -> completer
//   prdata/pready/pslverr            : completer -> requester
interface apb_reg_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB3 completer register bank.
//   apb_pclk   : clock
//   apb_preset : synchronous active-high reset
//   apb        : APB bus (slave modport): paddr, pwrite, psel, penable, pwdata
//                in; prdata, pready, pslverr out
//   ctrl_out   : current CTRL register value
// Map (offset from BASE_ADDR): 0x00 ID (RO), 0x04 CTRL (RW, [3:0] = wait
// states), 0x08 TXN_CNT (RO), 0x0C.. scratch (RW).
module apb_reg_slave #(
  parameter int                         APB_ADDR_WIDTH = 32,
  parameter int                         APB_DATA_WIDTH = 32,
  parameter int                         NUM_REGS       = 8,
  parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h1000_0000,
  parameter logic [APB_DATA_WIDTH-1:0]  ID_VALUE       = 32'hA0B0_0001
) (
  input  logic                      apb_pclk,
  input  logic                      apb_preset,
  apb_reg_slave_if.slave            apb,
  output logic [APB_DATA_WIDTH-1:0] ctrl_out
);

  localparam int                        IDX_W = $clog2(NUM_REGS);
  localparam logic [APB_ADDR_WIDTH-1:0] SPAN  = APB_ADDR_WIDTH'(4 * NUM_REGS);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      err_q;
  logic [3:0]                wcnt_q;

  logic [APB_DATA_WIDTH-1:0] ctrl_q;
  logic [APB_DATA_WIDTH-1:0] txn_q;
  logic [APB_DATA_WIDTH-1:0] scratch_q [NUM_REGS-3];

  logic [APB_ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]          idx;
  logic                      dec_err;
  logic                      setup;
  logic                      complete;
  logic [APB_DATA_WIDTH-1:0] rsel;

  // Address decode on the live bus; only sampled on the setup cycle.
  always_comb begin
    offset  = apb.paddr - BASE_ADDR;
    idx     = offset[IDX_W+1:2];
    dec_err = (apb.paddr[1:0] != 2'b00) ||
              (apb.paddr < BASE_ADDR)   ||
              (offset >= SPAN)          ||
              (apb.pwrite && (idx == IDX_W'(0) || idx == IDX_W'(2)));
  end

  assign setup = (state_q == IDLE) && apb.psel && !apb.penable;

  // State register plus the per-transfer latches.
  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        idx_q   <= idx;
        write_q <= apb.pwrite;
        wdata_q <= apb.pwdata;
        err_q   <= dec_err;
        // Wait count is taken from CTRL as it stands at setup, so a CTRL
        // write only affects transfers that start after it commits.
        wcnt_q  <= ctrl_q[3:0];
      end else if (state_q == ACCESS && apb.psel && wcnt_q != 4'd0) begin
        wcnt_q  <= wcnt_q - 4'd1;
      end
    end
  end

  // Next-state logic. psel dropping during ACCESS aborts without commit;
  // psel+penable seen in IDLE without a setup phase is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (apb.psel && !apb.penable) state_d = ACCESS;
      ACCESS:  if (!apb.psel || wcnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: completion is purely a function of registered state and psel.
  always_comb begin
    complete = (state_q == ACCESS) && apb.psel && (wcnt_q == 4'd0);
    rsel     = '0;
    case (idx_q)
      IDX_W'(0): rsel = ID_VALUE;
      IDX_W'(1): rsel = ctrl_q;
      IDX_W'(2): rsel = txn_q;
      default: begin
        for (int i = 3; i < NUM_REGS; i++)
          if (idx_q == IDX_W'(i)) rsel = scratch_q[i-3];
      end
    endcase
  end

  assign apb.pready  = complete;
  assign apb.pslverr = complete && err_q;
  assign apb.prdata  = (complete && !err_q) ? rsel : '0;
  assign ctrl_out    = ctrl_q;

  // Register bank. Writes and the transfer counter move only on an
  // error-free completion edge, using the latched address and data.
  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      ctrl_q <= '0;
      txn_q  <= '0;
      for (int i = 0; i < NUM_REGS - 3; i++) scratch_q[i] <= '0;
    end else if (complete && !err_q) begin
      txn_q <= txn_q + 1'b1;
      if (write_q) begin
        if (idx_q == IDX_W'(1)) ctrl_q <= wdata_q;
        for (int i = 3; i < NUM_REGS; i++)
          if (idx_q == IDX_W'(i)) scratch_q[i-3] <= wdata_q;
      end
    end
  end

endmodule
